// File: rtl/leaf_pkt_pkg.sv
// BFT packet layout helpers: field positions, type encodings and pack/unpack
// functions shared by the leaf transmit path.
package leaf_pkt_pkg;

  localparam int MAX_PKT_BITS = 256;

  typedef logic [MAX_PKT_BITS-1:0] pkt_max_t;

  typedef enum logic {
    TYPE_DATA   = 1'b0,
    TYPE_CREDIT = 1'b1
  } pkt_type_e;

  function automatic int seq_lsb(input int payload_bits);
    return payload_bits;
  endfunction

  function automatic int port_lsb(input int addr_bits, input int payload_bits);
    return addr_bits + payload_bits;
  endfunction

  function automatic int leaf_lsb(input int port_bits, input int addr_bits, input int payload_bits);
    return port_bits + addr_bits + payload_bits;
  endfunction

  function automatic int type_pos(input int leaf_bits, input int port_bits, input int addr_bits,
                                  input int payload_bits);
    return leaf_bits + port_bits + addr_bits + payload_bits;
  endfunction

  function automatic int valid_pos(input int leaf_bits, input int port_bits, input int addr_bits,
                                   input int payload_bits);
    return leaf_bits + port_bits + addr_bits + payload_bits + 1;
  endfunction

  function automatic pkt_max_t field_mask(input int width);
    return (pkt_max_t'(1) << width) - pkt_max_t'(1);
  endfunction

  // Extract a field of up to 64 bits from a zero-extended packet word.
  function automatic logic [63:0] pkt_field(input pkt_max_t pkt, input int lsb, input int width);
    return 64'((pkt >> lsb) & field_mask(width));
  endfunction

  function automatic pkt_max_t pack_pkt(input pkt_type_e pkt_type,
                                        input logic [63:0] leaf,
                                        input logic [63:0] port,
                                        input logic [63:0] seq,
                                        input logic [63:0] payload,
                                        input int leaf_bits,
                                        input int port_bits,
                                        input int addr_bits,
                                        input int payload_bits);
    pkt_max_t p;
    p = pkt_max_t'(payload) & field_mask(payload_bits);
    p = p | ((pkt_max_t'(seq) & field_mask(addr_bits)) << seq_lsb(payload_bits));
    p = p | ((pkt_max_t'(port) & field_mask(port_bits)) << port_lsb(addr_bits, payload_bits));
    p = p | ((pkt_max_t'(leaf) & field_mask(leaf_bits))
             << leaf_lsb(port_bits, addr_bits, payload_bits));
    p[type_pos(leaf_bits, port_bits, addr_bits, payload_bits)] = pkt_type;
    p[valid_pos(leaf_bits, port_bits, addr_bits, payload_bits)] = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among NUM_REQ requesters, search starts
// at a registered pointer that moves just past the last winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;
  logic             found;
  int               idx;

  always_comb begin
    grant    = '0;
    ptr_next = ptr_reg;
    found    = 1'b0;
    idx      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr_reg) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_next   = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/leaf_tx_arbiter.sv
// Leaf outbound path: round-robin merge of user streams into BFT data packets
// with per-port routing and credit flow control. LEAF_TX_STATS_EN adds counters.
module leaf_tx_arbiter
  import leaf_pkt_pkg::*;
#(
  parameter int PAYLOAD_BITS       = 32,
  parameter int NUM_LEAF_BITS      = 4,
  parameter int NUM_PORT_BITS      = 4,
  parameter int NUM_ADDR_BITS      = 7,
  parameter int PACKET_BITS        = 1 + 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS,
  parameter int NUM_OUT_PORTS      = 4,
  parameter int NUM_BRAM_ADDR_BITS = 7,
  parameter int INIT_CREDITS       = 2 ** NUM_BRAM_ADDR_BITS
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
  input  logic                                    cfg_we,
  input  logic [NUM_PORT_BITS-1:0]                cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]                cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]                cfg_dest_port,
  input  logic [PACKET_BITS-1:0]                  din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft,
  output logic                                    credit_overflow
`ifdef LEAF_TX_STATS_EN
  ,
  output logic [NUM_OUT_PORTS*32-1:0]             tx_count,
  output logic [NUM_OUT_PORTS*32-1:0]             stall_count
`endif
);

  localparam int N   = NUM_OUT_PORTS;
  localparam int LB  = NUM_LEAF_BITS;
  localparam int PB  = NUM_PORT_BITS;
  localparam int AB  = NUM_ADDR_BITS;
  localparam int CW  = NUM_BRAM_ADDR_BITS + 1;
  localparam int SW  = CW + 1;
  localparam int GW  = (N > 1) ? $clog2(N) : 1;
  localparam int PORT_LSB  = port_lsb(AB, PAYLOAD_BITS);
  localparam int TYPE_POS  = type_pos(LB, PB, AB, PAYLOAD_BITS);
  localparam int VALID_POS = valid_pos(LB, PB, AB, PAYLOAD_BITS);

  pkt_max_t         din_wide;
  logic             ret_vld;
  logic [PB-1:0]    ret_port;
  logic [CW-1:0]    ret_inc;

  assign din_wide = pkt_max_t'(din_leaf_bft2interface);
  assign ret_vld  = 1'(pkt_field(din_wide, VALID_POS, 1)) &&
                    (pkt_type_e'(1'(pkt_field(din_wide, TYPE_POS, 1))) == TYPE_CREDIT);
  assign ret_port = PB'(pkt_field(din_wide, PORT_LSB, PB));
  assign ret_inc  = CW'(pkt_field(din_wide, 0, CW));

  logic [N-1:0]    eligible;
  logic [N-1:0]    grant;
  logic [N-1:0]    ovf_hit;
  logic [N*LB-1:0] leaf_flat;
  logic [N*PB-1:0] port_flat;
  logic [N*AB-1:0] seq_flat;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_port
      logic [CW-1:0] credit_reg;
      logic [CW-1:0] credit_next;
      logic [SW-1:0] credit_sum;
      logic [AB-1:0] seq_reg;
      logic          tbl_vld_reg;
      logic [LB-1:0] leaf_reg;
      logic [PB-1:0] port_reg;
      logic          ret_hit;
      logic          cfg_hit;

      // Port indices are compared at full field width so out-of-range
      // indices never alias onto a real port.
      assign ret_hit = ret_vld && (ret_port == PB'(gi));
      assign cfg_hit = cfg_we && (cfg_port == PB'(gi));

      assign credit_sum  = SW'(credit_reg) + (ret_hit ? SW'(ret_inc) : SW'(0)) - SW'(grant[gi]);
      assign ovf_hit[gi] = credit_sum > SW'(INIT_CREDITS);
      assign credit_next = ovf_hit[gi] ? CW'(INIT_CREDITS) : credit_sum[CW-1:0];

      assign eligible[gi] = vld_user2interface[gi] && tbl_vld_reg && (credit_reg != '0);

      assign leaf_flat[gi*LB +: LB] = leaf_reg;
      assign port_flat[gi*PB +: PB] = port_reg;
      assign seq_flat[gi*AB +: AB]  = seq_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          credit_reg  <= CW'(INIT_CREDITS);
          seq_reg     <= '0;
          tbl_vld_reg <= 1'b0;
          leaf_reg    <= '0;
          port_reg    <= '0;
        end else begin
          credit_reg <= credit_next;
          if (grant[gi]) begin
            seq_reg <= seq_reg + AB'(1);
          end
          if (cfg_hit) begin
            tbl_vld_reg <= 1'b1;
            leaf_reg    <= cfg_dest_leaf;
            port_reg    <= cfg_dest_port;
          end
        end
      end

`ifdef LEAF_TX_STATS_EN
      logic [31:0] tx_cnt_reg;
      logic [31:0] stall_cnt_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          tx_cnt_reg    <= '0;
          stall_cnt_reg <= '0;
        end else begin
          tx_cnt_reg <= tx_cnt_reg + 32'(grant[gi]);
          if (vld_user2interface[gi] && (credit_reg == '0)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
          end
        end
      end

      assign tx_count[gi*32 +: 32]    = tx_cnt_reg;
      assign stall_count[gi*32 +: 32] = stall_cnt_reg;
`endif
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ(N)
  ) u_rr_arbiter (
    .clk   (clk),
    .reset (reset),
    .req   (eligible),
    .grant (grant)
  );

  assign ack_interface2user = grant;

  logic [GW-1:0]          grant_idx;
  pkt_max_t               pkt_full;
  logic [PACKET_BITS-1:0] dout_next;
  logic [PACKET_BITS-1:0] dout_reg;
  logic                   overflow_reg;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        grant_idx = GW'(i);
      end
    end
  end

  always_comb begin
    pkt_full  = pack_pkt(TYPE_DATA,
                         64'(leaf_flat[int'(grant_idx)*LB +: LB]),
                         64'(port_flat[int'(grant_idx)*PB +: PB]),
                         64'(seq_flat[int'(grant_idx)*AB +: AB]),
                         64'(din_leaf_user2interface[int'(grant_idx)*PAYLOAD_BITS +: PAYLOAD_BITS]),
                         LB, PB, AB, PAYLOAD_BITS);
    dout_next = (|grant) ? pkt_full[PACKET_BITS-1:0] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      dout_reg <= dout_next;
      if (|ovf_hit) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign dout_leaf_interface2bft = dout_reg;
  assign credit_overflow         = overflow_reg;

endmodule

// File: tb/tb_leaf_tx_arbiter.sv
// Directed bench for leaf_tx_arbiter: stimulus pushes expected packets into a
// queue, a negedge monitor pops and compares whatever the DUT emits.
module tb_leaf_tx_arbiter;

  localparam int N  = 4;
  localparam int PK = 49;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*32-1:0] din_user;
  logic [N-1:0]    vld;
  logic [N-1:0]    ack;
  logic            cfg_we;
  logic [3:0]      cfg_port;
  logic [3:0]      cfg_dest_leaf;
  logic [3:0]      cfg_dest_port;
  logic [PK-1:0]   bft_in;
  logic [PK-1:0]   dout;
  logic            credit_overflow;
`ifdef LEAF_TX_STATS_EN
  logic [N*32-1:0] tx_count;
  logic [N*32-1:0] stall_count;
`endif

  always #5 clk = ~clk;

  leaf_tx_arbiter #(
    .PAYLOAD_BITS       (32),
    .NUM_LEAF_BITS      (4),
    .NUM_PORT_BITS      (4),
    .NUM_ADDR_BITS      (7),
    .NUM_OUT_PORTS      (N),
    .NUM_BRAM_ADDR_BITS (7),
    .INIT_CREDITS       (4)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_user2interface (din_user),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .cfg_we                  (cfg_we),
    .cfg_port                (cfg_port),
    .cfg_dest_leaf           (cfg_dest_leaf),
    .cfg_dest_port           (cfg_dest_port),
    .din_leaf_bft2interface  (bft_in),
    .dout_leaf_interface2bft (dout),
    .credit_overflow         (credit_overflow)
`ifdef LEAF_TX_STATS_EN
    ,
    .tx_count                (tx_count),
    .stall_count             (stall_count)
`endif
  );

  int            errors = 0;
  int            checks = 0;
  int            word_ctr = 0;
  logic [PK-1:0] exp_q[$];
  logic [PK-1:0] mon_exp;
  logic [3:0]    tb_leaf[N];
  logic [3:0]    tb_port[N];
  logic [6:0]    tb_seq[N];
  bit            fixed_en = 1'b0;
  logic [31:0]   fixed_word = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [PK-1:0] credit_pkt(input logic ty, input logic [3:0] port,
                                               input logic [31:0] inc);
    return {1'b1, ty, 4'h0, port, 7'h0, inc};
  endfunction

  task automatic drive_din();
    for (int i = 0; i < N; i++) begin
      din_user[i*32 +: 32] = {4'(i), 4'h5, 24'(word_ctr)};
    end
    if (fixed_en) din_user[31:0] = fixed_word;
  endtask

  // One cycle: drive vld, check ack at negedge, queue the expected packet.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] exp_ack);
    vld = v;
    drive_din();
    @(negedge clk);
    check($sformatf("ack@%0d", word_ctr), 64'(ack), 64'(exp_ack));
    for (int i = 0; i < N; i++) begin
      if (exp_ack[i]) begin
        exp_q.push_back({1'b1, 1'b0, tb_leaf[i], tb_port[i], tb_seq[i], din_user[i*32 +: 32]});
        $display("grant port %0d seq %0d data %h", i, tb_seq[i], din_user[i*32 +: 32]);
        tb_seq[i] = tb_seq[i] + 7'd1;
      end
    end
    @(posedge clk);
    #1;
    bft_in = '0;
    cfg_we = 1'b0;
    word_ctr++;
  endtask

  task automatic cfg(input int p, input logic [3:0] l, input logic [3:0] dp);
    cfg_we        = 1'b1;
    cfg_port      = 4'(p);
    cfg_dest_leaf = l;
    cfg_dest_port = dp;
    if (p < N) begin
      tb_leaf[p] = l;
      tb_port[p] = dp;
    end
    step('0, '0);
  endtask

  task automatic repeat_step(input int n, input logic [N-1:0] v, input logic [N-1:0] exp_ack);
    for (int k = 0; k < n; k++) step(v, exp_ack);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (dout[PK-1] === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dout_unexpected: got %h required no packet", dout);
        end else begin
          mon_exp = exp_q.pop_front();
          check("dout_pkt", 64'(dout), 64'(mon_exp));
          $display("pkt leaf %0d port %0d seq %0d data %h", dout[46:43], dout[42:39],
                   dout[38:32], dout[31:0]);
        end
      end else begin
        check("dout_idle", 64'(dout), 64'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; vld = '1; din_user = '0; cfg_we = 1'b0; cfg_port = '0;
    cfg_dest_leaf = '0; cfg_dest_port = '0; bft_in = '0;
    for (int i = 0; i < N; i++) begin
      tb_leaf[i] = '0; tb_port[i] = '0; tb_seq[i] = '0;
    end
    @(negedge clk);
    check("reset_dout", 64'(dout), 64'h0);
    check("reset_ack", 64'(ack), 64'h0);
    check("reset_ovf", 64'(credit_overflow), 64'h0);
    vld = '0;
    @(posedge clk); #1;
    reset = 1'b1;

    // First packet with a hand-built expected word.
    cfg(0, 4'd3, 4'd2);
    fixed_en = 1'b1; fixed_word = 32'hDEADBEEF;
    step(4'b0001, 4'b0001);
    fixed_en = 1'b0;
    check("dout_first", 64'(dout), 64'(49'h1_1900_DEAD_BEEF));

    // Round robin continues from port 1 after the grant to port 0.
    cfg(1, 4'd5, 4'd1);
    cfg(2, 4'd6, 4'd0);
    cfg(3, 4'd7, 4'd3);
    step(4'b1111, 4'b0010); step(4'b1111, 4'b0100);
    step(4'b1111, 4'b1000); step(4'b1111, 4'b0001);
    step(4'b1111, 4'b0010); step(4'b1111, 4'b0100);
    step(4'b1111, 4'b1000); step(4'b1111, 4'b0001);

    // Reset with a packet on dout: cleared at once, packet dropped.
    step(4'b1111, 4'b0010);
    reset = 1'b0;
    #1;
    check("midreset_dout", 64'(dout), 64'h0);
    check("midreset_ack", 64'(ack), 64'h0);
    exp_q.delete();
    for (int i = 0; i < N; i++) tb_seq[i] = '0;
    vld = '0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Credit exhaustion on port 1; port 3 left unconfigured.
    cfg(0, 4'd3, 4'd2);
    cfg(1, 4'd9, 4'd4);
    cfg(2, 4'd6, 4'd0);
    cfg(5, 4'd15, 4'd15);
    repeat_step(2, 4'b1010, 4'b0010);
    cfg(1, 4'd10, 4'd6);
    repeat_step(2, 4'b1010, 4'b0010);
    repeat_step(2, 4'b1010, 4'b0000);
    bft_in = credit_pkt(1'b1, 4'd5, 32'd2);
    step(4'b1010, 4'b0000);
    bft_in = credit_pkt(1'b0, 4'd1, 32'd2);
    step(4'b1010, 4'b0000);
    step(4'b1010, 4'b0000);
    bft_in = credit_pkt(1'b1, 4'd1, 32'd2);
    step(4'b1010, 4'b0000);
    repeat_step(2, 4'b1010, 4'b0010);
    repeat_step(2, 4'b1010, 4'b0000);

    // Same-cycle grant and return on port 2: 2 + 3 - 1 = 4, no overflow.
    repeat_step(2, 4'b0100, 4'b0100);
    bft_in = credit_pkt(1'b1, 4'd2, 32'd3);
    step(4'b0100, 4'b0100);
    check("ovf_exact_full", 64'(credit_overflow), 64'h0);
    repeat_step(4, 4'b0100, 4'b0100);
    step(4'b0100, 4'b0000);
    check("ovf_after_port2", 64'(credit_overflow), 64'h0);

    // Return at full credits on port 0 saturates and sets the sticky flag.
    bft_in = credit_pkt(1'b1, 4'd0, 32'd5);
    step(4'b0000, 4'b0000);
    check("ovf_set", 64'(credit_overflow), 64'h1);
    repeat_step(4, 4'b0001, 4'b0001);
    step(4'b0001, 4'b0000);
    check("ovf_sticky", 64'(credit_overflow), 64'h1);
    vld = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ovf_cleared", 64'(credit_overflow), 64'h0);
    check("final_reset_dout", 64'(dout), 64'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat_step(2, 4'b0000, 4'b0000);

    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
